// File: rtl/pe_pkg.sv
// Shared PE definitions: IFPAD sequencer states, default field widths,
// the latched layer-row configuration and its validity rule.
package pe_pkg;

  localparam int ConfDWd  = 4;
  localparam int PConfDWd = 3;
  localparam int RowWd    = 6;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_INIT   = 3'd1,
    ST_RUN    = 3'd2,
    ST_POP    = 3'd3,
    ST_NXTROW = 3'd4,
    ST_DONE   = 3'd5
  } IfSeqState;

  typedef struct packed {
    logic [ConfDWd-1:0]  iflen;
    logic [ConfDWd-1:0]  filtw;
    logic [ConfDWd-1:0]  stride;
    logic [PConfDWd-1:0] pch;
    logic [RowWd-1:0]    rows;
  } IfSeqCfg;

  // A row must hold at least one full window, and no field may be zero.
  function automatic logic cfg_valid(input IfSeqCfg c);
    return (c.iflen >= c.filtw) &&
           (c.iflen  != {ConfDWd{1'b0}}) &&
           (c.filtw  != {ConfDWd{1'b0}}) &&
           (c.stride != {ConfDWd{1'b0}}) &&
           (c.pch    != {PConfDWd{1'b0}}) &&
           (c.rows   != {RowWd{1'b0}});
  endfunction

endpackage

// File: rtl/ifpad_seq_cnt.sv
// Clear/enable up-counter. o_tc flags that the next increment would pass i_tc,
// which covers both "last beat" (inc=1) and "last window" (inc=stride) tests.
module ifpad_seq_cnt #(
  parameter int Wd = 4
) (
  input  logic          i_clk,
  input  logic          i_rstn,
  input  logic          i_clr,
  input  logic          i_en,
  input  logic [Wd-1:0] i_inc,
  input  logic [Wd-1:0] i_tc,
  output logic          o_tc
);

  logic [Wd-1:0] r_cnt;
  logic [Wd:0]   w_nxt;

  assign w_nxt = {1'b0, r_cnt} + {1'b0, i_inc};
  assign o_tc  = (w_nxt > {1'b0, i_tc});

  // Count register; clear wins over enable.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_cnt <= {Wd{1'b0}};
    end else if (i_clr) begin
      r_cnt <= {Wd{1'b0}};
    end else if (i_en) begin
      r_cnt <= w_nxt[Wd-1:0];
    end else begin
      r_cnt <= r_cnt;
    end
  end

endmodule

// File: rtl/ifpad_seq.sv
// IFPAD sequencer: slides a width-R window across each IF row and drives the pad's cont bundle.
// Define IFPAD_SEQ_PERF_EN to add the o_perf_stall saturating stall counter.
import pe_pkg::*;

module ifpad_seq #(
  parameter int ConfDWd  = pe_pkg::ConfDWd,
  parameter int PConfDWd = pe_pkg::PConfDWd,
  parameter int RowWd    = pe_pkg::RowWd
) (
  input  logic                i_clk,
  input  logic                i_rstn,
  input  logic                i_start,
  input  logic                i_abort,
  input  logic [ConfDWd-1:0]  i_cfg_iflen,
  input  logic [ConfDWd-1:0]  i_cfg_filtw,
  input  logic [ConfDWd-1:0]  i_cfg_stride,
  input  logic [PConfDWd-1:0] i_cfg_pch,
  input  logic [RowWd-1:0]    i_cfg_rows,
  input  logic                i_stall,
  input  logic                i_beat,
  output logic                o_busy,
  output logic                o_err,
  output logic [ConfDWd-1:0]  o_cont_IFLen,
  output logic [ConfDWd-1:0]  o_cont_PopU,
  output logic [PConfDWd-1:0] o_cont_Pch,
  output logic                o_cont_start,
  output logic                o_cont_reset,
  output logic                o_cont_pop,
  output logic                o_cont_nxtRow,
  output logic                o_cont_done,
  output logic                o_cont_stall
`ifdef IFPAD_SEQ_PERF_EN
  ,
  output logic [15:0]         o_perf_stall
`endif
);

  localparam int BeatWd = ConfDWd + PConfDWd;
  localparam int PosWd  = ConfDWd + 2;

  IfSeqState r_state;
  IfSeqCfg   r_cfg;
  IfSeqCfg   w_cfg_in;
  logic      r_busy, r_err, r_start, r_reset, r_pop, r_nxt, r_done, r_stall;
  logic      w_fire, w_win_done, w_beat_tc, w_pos_tc, w_row_tc;
  logic      w_beat_clr, w_pos_clr, w_row_clr;
  logic [BeatWd-1:0] w_win_beats_m1;

  assign w_cfg_in = '{iflen: i_cfg_iflen, filtw: i_cfg_filtw, stride: i_cfg_stride,
                      pch: i_cfg_pch, rows: i_cfg_rows};

  assign w_win_beats_m1 = ({{PConfDWd{1'b0}}, r_cfg.filtw} * {{ConfDWd{1'b0}}, r_cfg.pch})
                        - {{(BeatWd-1){1'b0}}, 1'b1};

  // A stalled beat is not a beat: it neither counts nor completes a window.
  assign w_fire     = (r_state == ST_RUN) && i_beat && !i_stall;
  assign w_win_done = w_fire && w_beat_tc;
  assign w_beat_clr = i_abort || (r_state != ST_RUN) || w_win_done;
  assign w_pos_clr  = i_abort || (r_state == ST_INIT) || (r_state == ST_NXTROW);
  assign w_row_clr  = i_abort || (r_state == ST_INIT);

  ifpad_seq_cnt #(.Wd(BeatWd)) u_beat (
    .i_clk (i_clk),
    .i_rstn(i_rstn),
    .i_clr (w_beat_clr),
    .i_en  (w_fire),
    .i_inc ({{(BeatWd-1){1'b0}}, 1'b1}),
    .i_tc  (w_win_beats_m1),
    .o_tc  (w_beat_tc)
  );

  // pos+stride > iflen-R is the last-window test, evaluated at ConfDWd+2 bits.
  ifpad_seq_cnt #(.Wd(PosWd)) u_pos (
    .i_clk (i_clk),
    .i_rstn(i_rstn),
    .i_clr (w_pos_clr),
    .i_en  (r_state == ST_POP),
    .i_inc ({2'b00, r_cfg.stride}),
    .i_tc  ({2'b00, r_cfg.iflen - r_cfg.filtw}),
    .o_tc  (w_pos_tc)
  );

  ifpad_seq_cnt #(.Wd(RowWd)) u_row (
    .i_clk (i_clk),
    .i_rstn(i_rstn),
    .i_clr (w_row_clr),
    .i_en  (r_state == ST_NXTROW),
    .i_inc ({{(RowWd-1){1'b0}}, 1'b1}),
    .i_tc  (r_cfg.rows - {{(RowWd-1){1'b0}}, 1'b1}),
    .o_tc  (w_row_tc)
  );

  // Sequencer FSM with registered control pulses and latched configuration.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_state <= ST_IDLE;
      r_cfg   <= {$bits(IfSeqCfg){1'b0}};
      r_busy  <= 1'b0;
      r_err   <= 1'b0;
      r_start <= 1'b0;
      r_reset <= 1'b0;
      r_pop   <= 1'b0;
      r_nxt   <= 1'b0;
      r_done  <= 1'b0;
      r_stall <= 1'b0;
    end else begin
      r_err   <= 1'b0;
      r_start <= 1'b0;
      r_reset <= 1'b0;
      r_pop   <= 1'b0;
      r_nxt   <= 1'b0;
      r_done  <= 1'b0;
      r_stall <= i_stall;
      if (i_abort) begin
        r_state <= ST_IDLE;
        r_reset <= 1'b1;
        r_busy  <= 1'b0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (i_start && cfg_valid(w_cfg_in)) begin
              r_cfg   <= w_cfg_in;
              r_state <= ST_INIT;
              r_start <= 1'b1;
              r_reset <= 1'b1;
              r_busy  <= 1'b1;
            end else if (i_start) begin
              r_err <= 1'b1;
            end else begin
              r_state <= ST_IDLE;
            end
          end
          ST_INIT: r_state <= ST_RUN;
          ST_RUN: begin
            if (w_win_done && w_pos_tc) begin
              r_state <= ST_NXTROW;
              r_nxt   <= 1'b1;
            end else if (w_win_done) begin
              r_state <= ST_POP;
              r_pop   <= 1'b1;
            end else begin
              r_state <= ST_RUN;
            end
          end
          ST_POP: r_state <= ST_RUN;
          ST_NXTROW: begin
            if (w_row_tc) begin
              r_state <= ST_DONE;
              r_done  <= 1'b1;
            end else begin
              r_state <= ST_RUN;
            end
          end
          ST_DONE: begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end
          default: begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign o_busy        = r_busy;
  assign o_err         = r_err;
  assign o_cont_IFLen  = r_cfg.iflen;
  assign o_cont_PopU   = r_cfg.stride;
  assign o_cont_Pch    = r_cfg.pch;
  assign o_cont_start  = r_start;
  assign o_cont_reset  = r_reset;
  assign o_cont_pop    = r_pop;
  assign o_cont_nxtRow = r_nxt;
  assign o_cont_done   = r_done;
  assign o_cont_stall  = r_stall;

`ifdef IFPAD_SEQ_PERF_EN
  logic [15:0] r_perf_stall;

  // Saturating count of stalled RUN cycles; survives DONE until the next INIT.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_perf_stall <= 16'd0;
    end else if (i_abort || (r_state == ST_INIT)) begin
      r_perf_stall <= 16'd0;
    end else if ((r_state == ST_RUN) && i_stall && (r_perf_stall != 16'hFFFF)) begin
      r_perf_stall <= r_perf_stall + 16'd1;
    end else begin
      r_perf_stall <= r_perf_stall;
    end
  end

  assign o_perf_stall = r_perf_stall;
`endif

endmodule

// File: tb/tb_ifpad_seq.sv
// Self-checking bench for ifpad_seq. The reference keeps a queue of pending work
// (beats still needed per window, then one-cycle pop/nxtRow/done events).
module tb_ifpad_seq;

  logic       i_clk = 1'b0;
  logic       i_rstn, i_start, i_abort, i_stall, i_beat;
  logic [3:0] i_cfg_iflen, i_cfg_filtw, i_cfg_stride;
  logic [2:0] i_cfg_pch;
  logic [5:0] i_cfg_rows;
  logic       o_busy, o_err, o_cont_start, o_cont_reset, o_cont_pop;
  logic       o_cont_nxtRow, o_cont_done, o_cont_stall;
  logic [3:0] o_cont_IFLen, o_cont_PopU;
  logic [2:0] o_cont_Pch;
`ifdef IFPAD_SEQ_PERF_EN
  logic [15:0] o_perf_stall;
`endif

  ifpad_seq dut (
    .i_clk(i_clk), .i_rstn(i_rstn), .i_start(i_start), .i_abort(i_abort),
    .i_cfg_iflen(i_cfg_iflen), .i_cfg_filtw(i_cfg_filtw), .i_cfg_stride(i_cfg_stride),
    .i_cfg_pch(i_cfg_pch), .i_cfg_rows(i_cfg_rows), .i_stall(i_stall), .i_beat(i_beat),
    .o_busy(o_busy), .o_err(o_err), .o_cont_IFLen(o_cont_IFLen), .o_cont_PopU(o_cont_PopU),
    .o_cont_Pch(o_cont_Pch), .o_cont_start(o_cont_start), .o_cont_reset(o_cont_reset),
    .o_cont_pop(o_cont_pop), .o_cont_nxtRow(o_cont_nxtRow), .o_cont_done(o_cont_done),
`ifdef IFPAD_SEQ_PERF_EN
    .o_perf_stall(o_perf_stall),
`endif
    .o_cont_stall(o_cont_stall)
  );

  always #5 i_clk = ~i_clk;

  int checks = 0;
  int errors = 0;

  // Reference model state. Queue codes: >0 beats left, -5 init, -1 pop, -2 nxtRow, -3 done.
  int         q[$];
  logic [3:0] m_iflen = 4'd0, m_stride = 4'd0;
  logic [2:0] m_pch = 3'd0;
  logic       e_busy = 1'b0, e_err = 1'b0, e_start = 1'b0, e_reset = 1'b0;
  logic       e_pop = 1'b0, e_nxt = 1'b0, e_done = 1'b0, e_stall = 1'b0;
  int         m_perf = 0;

  logic [18:0] w_dut, w_exp;
  assign w_dut = {o_busy, o_err, o_cont_start, o_cont_reset, o_cont_pop, o_cont_nxtRow,
                  o_cont_done, o_cont_stall, o_cont_IFLen, o_cont_PopU, o_cont_Pch};
  assign w_exp = {e_busy, e_err, e_start, e_reset, e_pop, e_nxt, e_done, e_stall,
                  m_iflen, m_stride, m_pch};

  // Applies one cycle of inputs, advances the reference, and waits past the edge.
  task automatic tick(input logic st, input logic ab, input logic sl, input logic bt);
    int iflen, r, s, k;
    i_start = st; i_abort = ab; i_stall = sl; i_beat = bt;
    {e_err, e_start, e_reset, e_pop, e_nxt, e_done} = 6'b000000;
    if (ab) begin
      q.delete();
      e_reset = 1'b1;
      m_perf  = 0;
    end else if (q.size() == 0) begin
      if (st) begin
        if (i_cfg_iflen >= i_cfg_filtw && i_cfg_iflen != 4'd0 && i_cfg_filtw != 4'd0 &&
            i_cfg_stride != 4'd0 && i_cfg_pch != 3'd0 && i_cfg_rows != 6'd0) begin
          m_iflen = i_cfg_iflen; m_stride = i_cfg_stride; m_pch = i_cfg_pch;
          iflen = int'(i_cfg_iflen); r = int'(i_cfg_filtw); s = int'(i_cfg_stride);
          k = r * int'(i_cfg_pch);
          q.push_back(-5);
          for (int row = 0; row < int'(i_cfg_rows); row++) begin
            for (int p = 0; p + s + r <= iflen; p += s) begin
              q.push_back(k);
              q.push_back(-1);
            end
            q.push_back(k);
            q.push_back(-2);
          end
          q.push_back(-3);
        end else begin
          e_err = 1'b1;
        end
      end
    end else if (q[0] < 0) begin
      if (q[0] == -5) m_perf = 0;
      void'(q.pop_front());
    end else begin
      if (sl && m_perf < 65535) m_perf++;
      if (bt && !sl) begin
        q[0] = q[0] - 1;
        if (q[0] == 0) void'(q.pop_front());
      end
    end
    if (!ab && q.size() > 0) begin
      case (q[0])
        -5: begin e_start = 1'b1; e_reset = 1'b1; end
        -1: e_pop  = 1'b1;
        -2: e_nxt  = 1'b1;
        -3: e_done = 1'b1;
        default: ;
      endcase
    end
    e_busy  = (q.size() != 0);
    e_stall = sl;
    @(posedge i_clk);
    #1;
  endtask

  task automatic set_cfg(input int a, input int b, input int c, input int d, input int e);
    i_cfg_iflen = 4'(a); i_cfg_filtw = 4'(b); i_cfg_stride = 4'(c);
    i_cfg_pch = 3'(d); i_cfg_rows = 6'(e);
  endtask

  task automatic test_reset();
    i_rstn = 1'b0; i_start = 1'b0; i_abort = 1'b0; i_stall = 1'b0; i_beat = 1'b0;
    set_cfg(5, 3, 1, 1, 1);
    #2;
    checks++;
    if (w_dut !== 19'd0) begin
      errors++; $display("FAIL reset_values got %h want %h", w_dut, 19'd0);
    end
    @(negedge i_clk);
    i_rstn = 1'b1;
    tick(1'b0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (w_dut !== w_exp) begin
      errors++; $display("FAIL reset_idle got %h want %h", w_dut, w_exp);
    end
  endtask

  task automatic test_basic();
    longint unsigned pop_m = 0, nxt_m = 0, done_m = 0;
    int busy_n = 0;
    set_cfg(5, 3, 1, 1, 1);
    for (int c = 0; c < 60; c++) begin
      if (c > 0 && !e_busy) break;
      tick(c == 0, 1'b0, 1'b0, 1'b1);
      checks++;
      if (w_dut !== w_exp) begin
        errors++; $display("FAIL basic_cycle%0d got %h want %h", c, w_dut, w_exp);
      end
      if (o_busy) busy_n++;
      if (o_cont_pop) pop_m |= 64'd1 << c;
      if (o_cont_nxtRow) nxt_m |= 64'd1 << c;
      if (o_cont_done) done_m |= 64'd1 << c;
    end
    checks++;
    if (busy_n !== 14) begin errors++; $display("FAIL basic_busy got %0d want 14", busy_n); end
    checks++;
    if (pop_m !== ((64'd1 << 4) | (64'd1 << 8))) begin
      errors++; $display("FAIL basic_pop_cycles got %h want %h", pop_m, (64'd1 << 4) | (64'd1 << 8));
    end
    checks++;
    if (nxt_m !== (64'd1 << 12) || done_m !== (64'd1 << 13)) begin
      errors++; $display("FAIL basic_nxt_done got %h/%h want %h/%h", nxt_m, done_m, 64'd1 << 12, 64'd1 << 13);
    end
  endtask

  task automatic test_multi_row();
    int pops = 0, nxts = 0, dones = 0;
    set_cfg(7, 3, 2, 2, 2);
    tick(1'b1, 1'b0, 1'b0, 1'b0);
    for (int c = 0; c < 400 && e_busy; c++) begin
      tick(1'b0, 1'b0, 1'b0, $urandom_range(0, 3) != 0);
      checks++;
      if (w_dut !== w_exp) begin
        errors++; $display("FAIL multirow_cycle%0d got %h want %h", c, w_dut, w_exp);
      end
      pops += int'(o_cont_pop); nxts += int'(o_cont_nxtRow); dones += int'(o_cont_done);
    end
    checks++;
    if (pops !== 4 || nxts !== 2 || dones !== 1) begin
      errors++; $display("FAIL multirow_counts got %0d/%0d/%0d want 4/2/1", pops, nxts, dones);
    end
  endtask

  task automatic test_invalid();
    set_cfg(2, 3, 1, 1, 1);
    tick(1'b1, 1'b0, 1'b0, 1'b1);
    checks++;
    if ({o_err, o_busy, o_cont_start, o_cont_reset, o_cont_pop, o_cont_nxtRow, o_cont_done} !== 7'b1000000) begin
      errors++; $display("FAIL invalid_err got %b want 1000000",
        {o_err, o_busy, o_cont_start, o_cont_reset, o_cont_pop, o_cont_nxtRow, o_cont_done});
    end
    for (int c = 0; c < 8; c++) begin
      case (c % 4)
        0: set_cfg(0, 0, 1, 1, 1);
        1: set_cfg(9, 3, 0, 1, 1);
        2: set_cfg(9, 3, 1, 0, 1);
        default: set_cfg(9, 3, 1, 1, 0);
      endcase
      tick(c % 2 == 0, 1'b0, 1'b0, 1'b1);
      checks++;
      if (w_dut !== w_exp) begin
        errors++; $display("FAIL invalid_cycle%0d got %h want %h", c, w_dut, w_exp);
      end
    end
  endtask

  task automatic test_stall();
    int busy_n = 0, stall_n = 0;
    set_cfg(4, 2, 1, 1, 1);
    for (int c = 0; c < 60; c++) begin
      if (c > 0 && !e_busy) break;
      tick(c == 0, 1'b0, c >= 2 && c <= 5, 1'b1);
      checks++;
      if (w_dut !== w_exp) begin
        errors++; $display("FAIL stall_cycle%0d got %h want %h", c, w_dut, w_exp);
      end
      busy_n += int'(o_busy); stall_n += int'(o_cont_stall);
    end
    checks++;
    if (busy_n !== 15 || stall_n !== 4) begin
      errors++; $display("FAIL stall_time got busy %0d stall %0d want 15 4", busy_n, stall_n);
    end
`ifdef IFPAD_SEQ_PERF_EN
    tick(1'b0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (o_perf_stall !== 16'd4) begin
      errors++; $display("FAIL perf_stall got %0d want 4", o_perf_stall);
    end
`endif
  endtask

  task automatic test_abort();
    int pops = 0, dones = 0, busy_n = 0;
    set_cfg(5, 3, 1, 1, 1);
    tick(1'b1, 1'b0, 1'b0, 1'b1);
    for (int c = 0; c < 20 && pops == 0; c++) begin
      tick(1'b0, 1'b0, 1'b0, 1'b1);
      pops += int'(o_cont_pop);
    end
    tick(1'b0, 1'b0, 1'b0, 1'b1);
    tick(1'b0, 1'b1, 1'b0, 1'b1);
    checks++;
    if ({o_busy, o_cont_reset, o_cont_done} !== 3'b010 || w_dut !== w_exp) begin
      errors++; $display("FAIL abort_response got %h want %h", w_dut, w_exp);
    end
    tick(1'b0, 1'b0, 1'b0, 1'b1);
    for (int c = 0; c < 60; c++) begin
      if (c > 0 && !e_busy) break;
      tick(c == 0, 1'b0, 1'b0, 1'b1);
      checks++;
      if (w_dut !== w_exp) begin
        errors++; $display("FAIL abort_rerun_cycle%0d got %h want %h", c, w_dut, w_exp);
      end
      dones += int'(o_cont_done); busy_n += int'(o_busy);
    end
    checks++;
    if (dones !== 1 || busy_n !== 14) begin
      errors++; $display("FAIL abort_rerun got done %0d busy %0d want 1 14", dones, busy_n);
    end
  endtask

  task automatic test_start_in_run();
    int dones = 0;
    set_cfg(6, 2, 2, 1, 1);
    tick(1'b1, 1'b0, 1'b0, 1'b1);
    for (int c = 0; c < 80 && e_busy; c++) begin
      if (c == 3) set_cfg(9, 4, 1, 3, 2);
      tick(c == 3 || c == 6, 1'b0, 1'b0, 1'b1);
      checks++;
      if (w_dut !== w_exp) begin
        errors++; $display("FAIL startrun_cycle%0d got %h want %h", c, w_dut, w_exp);
      end
      dones += int'(o_cont_done);
    end
    checks++;
    if ({o_cont_IFLen, o_cont_PopU, o_cont_Pch} !== {4'd6, 4'd2, 3'd1} || dones !== 1) begin
      errors++; $display("FAIL startrun_cfg got %0d/%0d/%0d done %0d want 6/2/1 done 1",
        o_cont_IFLen, o_cont_PopU, o_cont_Pch, dones);
    end
  endtask

  task automatic test_random();
    int iflen;
    for (int it = 0; it < 20; it++) begin
      iflen = $urandom_range(1, 15);
      if ($urandom_range(0, 9) == 0)
        set_cfg(iflen, $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 3), $urandom_range(0, 2));
      else
        set_cfg(iflen, $urandom_range(1, iflen), $urandom_range(1, 15), $urandom_range(1, 3), $urandom_range(1, 2));
      tick(1'b1, 1'b0, 1'b0, 1'b0);
      checks++;
      if (w_dut !== w_exp) begin
        errors++; $display("FAIL random%0d_start got %h want %h", it, w_dut, w_exp);
      end
      for (int c = 0; c < 5000 && e_busy; c++) begin
        tick($urandom_range(0, 19) == 0, $urandom_range(0, 299) == 0,
             $urandom_range(0, 4) == 0, $urandom_range(0, 9) < 7);
        checks++;
        if (w_dut !== w_exp) begin
          errors++; $display("FAIL random%0d_cycle%0d got %h want %h", it, c, w_dut, w_exp);
        end
      end
      if (e_busy) begin
        checks++; errors++;
        $display("FAIL random%0d_timeout got busy want idle", it);
        tick(1'b0, 1'b1, 1'b0, 1'b0);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_multi_row();
    test_invalid();
    test_stall();
    test_abort();
    test_start_in_run();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
